// File: rtl/mux_arb_nx1_if.sv
// Handshake bundle for mux_arb_nx1: N_CH producer lanes in, one consumer lane out.
// master = producers/consumer side, slave = the arbitrating mux.
interface mux_arb_nx1_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_last,
        input  out_sel,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_last,
        output out_sel,
        output out_valid
    );
endinterface

// File: rtl/mux_arb_nx1.sv
// Registered N:1 stream mux with round-robin arbitration and packet locking.
// Define MUX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mux_arb_nx1 #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input logic          clk,
    input logic          rst,
    mux_arb_nx1_if.slave bus
);

    typedef enum logic [0:0] {
        StArb,
        StLock
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] w_lock_ch_nxt;

    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic             r_out_last;
    logic             w_out_last_nxt;
    logic [SEL_W-1:0] r_out_sel;
    logic [SEL_W-1:0] w_out_sel_nxt;

    logic             w_load;
    logic [SEL_W-1:0] w_cand;
    logic             w_arb_found;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_grant_vld;
    logic [SEL_W-1:0] w_grant_idx;
    logic [N_CH-1:0]  w_in_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;

    function automatic logic [SEL_W-1:0] f_next_ch(input logic [SEL_W-1:0] ch);
        if (ch == SEL_W'(N_CH - 1)) begin
            return '0;
        end
        return ch + SEL_W'(1);
    endfunction

    assign w_load = !r_out_valid || bus.out_ready;

    // Walk the channels once starting at ptr; the first valid one wins.
    always_comb begin : p_search
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_cand      = r_ptr;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!w_arb_found && bus.in_valid[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
            w_cand = f_next_ch(w_cand);
        end
    end

    always_comb begin : p_grant
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_in_ready  = '0;
        if (r_state == StLock) begin
            w_grant_vld = 1'b1;
            w_grant_idx = r_lock_ch;
        end else begin
            w_grant_vld = w_arb_found;
            w_grant_idx = w_arb_idx;
        end
        if (w_grant_vld && w_load && !rst) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_xfer     = w_grant_vld && w_load && !rst && bus.in_valid[w_grant_idx];
    assign w_sel_data = bus.in_data[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_sel_last = bus.in_last[w_grant_idx];

    always_comb begin : p_fsm
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_lock_ch_nxt   = r_lock_ch;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_out_sel_nxt   = r_out_sel;

        if (w_load) begin
            w_out_valid_nxt = w_xfer;
        end

        if (w_xfer) begin
            w_out_data_nxt = w_sel_data;
            w_out_last_nxt = w_sel_last;
            w_out_sel_nxt  = w_grant_idx;
            unique case (r_state)
                StArb: begin
                    if (w_sel_last) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                        w_ptr_nxt = '0;
`else
                        w_ptr_nxt = f_next_ch(w_grant_idx);
`endif
                    end else begin
                        w_state_nxt   = StLock;
                        w_lock_ch_nxt = w_grant_idx;
                    end
                end
                StLock: begin
                    if (w_sel_last) begin
                        w_state_nxt = StArb;
`ifdef MUX_ARB_FIXED_PRIO_EN
                        w_ptr_nxt   = '0;
`else
                        w_ptr_nxt   = f_next_ch(r_lock_ch);
`endif
                    end
                end
                default: begin
                    w_state_nxt = StArb;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StArb;
            r_ptr       <= '0;
            r_lock_ch   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_lock_ch   <= w_lock_ch_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_sel   <= w_out_sel_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_sel   = r_out_sel;

endmodule
